// File: rtl/lane_serializer_if.sv
// Word-in / bit-out port bundle for one transmit lane serializer.
// The striping stage drives the master side; the serializer is the slave.
interface lane_serializer_if;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic        data_out;
    logic        valid_out;
    logic        frame_start;
    logic        overflow;

    modport master (
        output data_in, valid_in,
        input  ready_out, data_out, valid_out, frame_start, overflow
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, data_out, valid_out, frame_start, overflow
    );
endinterface

// File: rtl/lane_serializer.sv
// Per-lane 32:1 serializer: MSB-first words in fixed 32-bit slots, idle fill,
// one-word holding buffer and a sticky flag for dropped words.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   SLOT_IDLE | current slot carries IDLE_WORD (valid_out = 0)
//   SLOT_DATA | current slot carries a data word (valid_out = 1)
module lane_serializer #(
    parameter logic [31:0] IDLE_WORD = 32'hBCBCBCBC
) (
    input logic              clk_32f,
    input logic              reset,
    lane_serializer_if.slave lane
);

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_DATA = 1'b1
    } slot_state_t;

    slot_state_t slot_state;
    logic [31:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic [31:0] hold_reg;
    logic        hold_valid;
    logic        overflow;
    logic        frame_start;

    logic boundary;
    logic ready;
    logic accept;
    logic drop;

    assign boundary = (bit_cnt == 5'd31);
    // The hold frees up on a boundary edge, so a new word can be taken there.
    assign ready    = !hold_valid || boundary;
    assign accept   = lane.valid_in && ready;
    assign drop     = lane.valid_in && !ready;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            slot_state  <= SLOT_IDLE;
            shift_reg   <= 32'h0;
            bit_cnt     <= 5'd31;
            hold_reg    <= 32'h0;
            hold_valid  <= 1'b0;
            overflow    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt + 5'd1;
            frame_start <= boundary;

            if (boundary) begin
                if (hold_valid) begin
                    shift_reg  <= hold_reg;
                    slot_state <= SLOT_DATA;
                end else begin
                    shift_reg  <= IDLE_WORD;
                    slot_state <= SLOT_IDLE;
                end
            end else begin
                shift_reg <= {shift_reg[30:0], 1'b0};
            end

            // Old hold word is read into the shifter above before being overwritten.
            if (accept) begin
                hold_reg   <= lane.data_in;
                hold_valid <= 1'b1;
            end else if (boundary) begin
                hold_valid <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign lane.data_out    = shift_reg[31];
    assign lane.valid_out   = (slot_state == SLOT_DATA);
    assign lane.frame_start = frame_start;
    assign lane.overflow    = overflow;
    assign lane.ready_out   = ready;

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer: walks slot by slot from reset, checking
// every serial bit, slot qualifiers, handshake and overflow against fixed words.
module tb_lane_serializer;

    localparam logic [31:0] IDLE = 32'hBCBCBCBC;

    logic clk_32f = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    lane_serializer_if lane ();

    lane_serializer #(.IDLE_WORD(IDLE)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .lane    (lane)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " data_out"},    32'(lane.data_out),    32'd0);
        chk({tag, " valid_out"},   32'(lane.valid_out),   32'd0);
        chk({tag, " frame_start"}, 32'(lane.frame_start), 32'd0);
        chk({tag, " ready_out"},   32'(lane.ready_out),   32'd1);
        chk({tag, " overflow"},    32'(lane.overflow),    32'd0);
    endtask

    // Crosses one boundary edge, then checks nbits bits of the slot it loaded.
    // Up to two words are offered, each for one cycle, on the edge at bit inj_at/inj2_at.
    task automatic run_slot(input string tag, input logic [31:0] word, input logic is_data,
                            input int nbits, input logic ovf_before, input int ovf_rise,
                            input int inj_at, input logic [31:0] inj_word, input logic inj_rdy,
                            input int inj2_at, input logic [31:0] inj2_word, input logic inj2_rdy);
        logic ovf_exp;
        @(posedge clk_32f);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_32f);
            ovf_exp = ovf_before || (ovf_rise >= 0 && i > ovf_rise);
            chk($sformatf("%s data_out bit %0d", tag, i),    32'(lane.data_out),    32'(word[31-i]));
            chk($sformatf("%s valid_out bit %0d", tag, i),   32'(lane.valid_out),   32'(is_data));
            chk($sformatf("%s frame_start bit %0d", tag, i), 32'(lane.frame_start), 32'(i == 0));
            chk($sformatf("%s overflow bit %0d", tag, i),    32'(lane.overflow),    32'(ovf_exp));
            lane.valid_in = 1'b0;
            lane.data_in  = 32'h0;
            if (i == inj_at) begin
                chk($sformatf("%s ready_out at bit %0d", tag, i), 32'(lane.ready_out), 32'(inj_rdy));
                lane.valid_in = 1'b1;
                lane.data_in  = inj_word;
            end
            if (i == inj2_at) begin
                chk($sformatf("%s ready_out at bit %0d", tag, i), 32'(lane.ready_out), 32'(inj2_rdy));
                lane.valid_in = 1'b1;
                lane.data_in  = inj2_word;
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        lane.valid_in = 1'b0;
        lane.data_in  = 32'h0;
        repeat (3) @(posedge clk_32f);
        @(negedge clk_32f);
        reset_checks("por");
        @(posedge clk_32f);
        #1 reset = 1'b0;

        // Three idle slots with no traffic.
        run_slot("idle1", IDLE, 1'b0, 32, 1'b0, -1, -1, 32'h0, 1'b0, -1, 32'h0, 1'b0);
        run_slot("idle2", IDLE, 1'b0, 32, 1'b0, -1, -1, 32'h0, 1'b0, -1, 32'h0, 1'b0);
        run_slot("idle3", IDLE, 1'b0, 32, 1'b0, -1, -1, 32'h0, 1'b0, -1, 32'h0, 1'b0);

        // Single word offered mid-slot at bit 5.
        run_slot("idle4", IDLE, 1'b0, 32, 1'b0, -1, 5, 32'hA5A50F0F, 1'b1, -1, 32'h0, 1'b0);
        run_slot("single", 32'hA5A50F0F, 1'b1, 32, 1'b0, -1, -1, 32'h0, 1'b0, -1, 32'h0, 1'b0);

        // Back-to-back on boundaries: first lands in the hold while an idle slot loads.
        run_slot("post_single", IDLE, 1'b0, 32, 1'b0, -1, 31, 32'h00000001, 1'b1, -1, 32'h0, 1'b0);
        run_slot("no_bypass", IDLE, 1'b0, 32, 1'b0, -1, 31, 32'h80000000, 1'b1, -1, 32'h0, 1'b0);
        run_slot("b2b_lsb", 32'h00000001, 1'b1, 32, 1'b0, -1, -1, 32'h0, 1'b0, -1, 32'h0, 1'b0);

        // Boundary collision: 12345678 held, DEADBEEF offered on the bit-31 edge.
        run_slot("b2b_msb", 32'h80000000, 1'b1, 32, 1'b0, -1, 10, 32'h12345678, 1'b1, 31, 32'hDEADBEEF, 1'b1);
        run_slot("held", 32'h12345678, 1'b1, 32, 1'b0, -1, -1, 32'h0, 1'b0, -1, 32'h0, 1'b0);

        // Overflow: second word two cycles later is dropped, flag rises on that edge.
        run_slot("collide", 32'hDEADBEEF, 1'b1, 32, 1'b0, 5, 3, 32'h11111111, 1'b1, 5, 32'h22222222, 1'b0);
        run_slot("after_drop", 32'h11111111, 1'b1, 32, 1'b1, -1, 20, 32'h0F0F0F0F, 1'b1, -1, 32'h0, 1'b0);

        // Reset at bit 10 of a data slot, with another word sitting in the hold.
        run_slot("truncated", 32'h0F0F0F0F, 1'b1, 11, 1'b1, -1, 2, 32'h77777777, 1'b1, -1, 32'h0, 1'b0);
        reset = 1'b1;
        @(posedge clk_32f);
        @(negedge clk_32f);
        reset_checks("mid_slot_reset");
        @(posedge clk_32f);
        #1 reset = 1'b0;

        run_slot("restart1", IDLE, 1'b0, 32, 1'b0, -1, -1, 32'h0, 1'b0, -1, 32'h0, 1'b0);
        run_slot("restart2", IDLE, 1'b0, 32, 1'b0, -1, -1, 32'h0, 1'b0, -1, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Per-lane parallel-to-serial converter on the transmit path, directly downstream of the two-lane striping stage; one instance per lane. Takes 32-bit words with a valid qualifier and emits them MSB-first, one bit per `clk_32f` cycle, in fixed 32-bit slots. Empty slots are filled with a programmable idle word so the receiver keeps word alignment. A one-word holding buffer decouples word arrival from slot boundaries, and lost words are flagged.

## Interface
- `IDLE_WORD`, default `32'hBCBCBCBC`: word transmitted in slots with no data.
- `clk_32f`  in  1  bit clock, 32× the per-lane word rate; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  32  word from the striping lane.
- `valid_in`  in  1  `data_in` is valid this cycle.
- `ready_out`  out  1  a word presented this cycle will be accepted.
- `data_out`  out  1  serial bit, MSB first.
- `valid_out`  out  1  high for all 32 bits of a data slot, low for idle slots.
- `frame_start`  out  1  high on bit 31 (first bit) of every slot, data or idle.
- `overflow`  out  1  sticky; set when a valid word is dropped, cleared only by reset.

## Operation
- State:
  - `shift_reg[31:0]`
  - `bit_cnt[4:0]`: index of the current slot position, 0 = first bit.
  - `slot_is_data`
  - `hold_reg[31:0]` and `hold_valid`: one-entry buffer.
  - `overflow`
- Outputs: `data_out = shift_reg[31]`, `valid_out = slot_is_data`, `frame_start = (bit_cnt == 0) && !first_cycle`. All are driven directly from registers.
- `ready_out = !hold_valid || (bit_cnt == 31)`.
- Accept: `valid_in && ready_out` writes `data_in` into `hold_reg` and sets `hold_valid`.
- Drop: `valid_in && !ready_out` discards the word, leaves `hold_reg` unchanged and sets `overflow`.
- `bit_cnt` increments every cycle and wraps from 31 to 0.
- Slot boundary (edge with `bit_cnt == 31`):
  - If `hold_valid`: `shift_reg <= hold_reg`, `slot_is_data <= 1`, and `hold_valid` is cleared, unless a word is accepted on the same edge, in which case it is refilled.
  - Else: `shift_reg <= IDLE_WORD`, `slot_is_data <= 0`.
  - There is no bypass. A word accepted on a boundary edge with the hold empty goes to `hold_reg`, and the slot being loaded on that edge is idle.
- Other edges: `shift_reg <= {shift_reg[30:0], 1'b0}`.
- Simultaneous events:
  - Load plus accept on a boundary: the old hold word goes to the shifter and the new word goes to the hold.
  - `reset` overrides everything.

## Timing
- Reset values, held while `reset = 1`: `shift_reg = 0`, `bit_cnt = 31`, `slot_is_data = 0`, `hold_valid = 0`, `overflow = 0`.
  - Resulting outputs: `data_out = 0`, `valid_out = 0`, `frame_start = 0`, `ready_out = 1`.
- First cycle after reset release (`bit_cnt = 31`) is a boundary. The first slot's bit 31 appears the cycle after.
- Latency:
  - Accepted at edge E with `bit_cnt = k` (k < 31): the word's MSB appears `31 − k + 1` cycles after E.
  - Accepted on a boundary edge: the MSB appears 33 cycles after E.
- Sustained throughput: 1 word per 32 cycles, with no drops when words arrive at most once per slot.
- Reset mid-slot: the slot is truncated, the hold is discarded, and the reset values above apply on the next edge.

## Test plan
- **Reset and idle:** release reset with `valid_in = 0` for 96 cycles.
  - `data_out` shows `BCBCBCBC` MSB-first three times.
  - `valid_out = 0` throughout.
  - `frame_start` pulses every 32 cycles, starting the cycle after the first boundary.
- **Single word:** present `32'hA5A50F0F` for 1 cycle at `bit_cnt = 5`.
  - Next slot serializes `A5A50F0F` with `valid_out = 1` for 32 cycles.
  - The following slot is idle.
- **Back-to-back:** present `32'h00000001`, then `32'h80000000` on consecutive slot boundaries.
  - Two consecutive data slots in arrival order.
  - Correct LSB/MSB positions.
  - `overflow = 0`.
- **Overflow:** present `32'h11111111`, then `32'h22222222` two cycles later (mid-slot).
  - The second word is dropped and `overflow` rises on that edge.
  - `11111111` is transmitted.
- **Boundary collision:** with a word held, present `32'hDEADBEEF` on the `bit_cnt = 31` edge.
  - `ready_out = 1` on that edge.
  - The held word is sent in the current slot and `DEADBEEF` in the next.
  - No overflow.
- **Reset mid-slot:** assert `reset` at bit 10 of a data slot.
  - All outputs take their reset values on the next edge.
  - On release, the transmission restarts with an idle slot.
